multicycle_controller: RTL and testbench

Control FSM that sequences the shared ALU, register file, memory port and PC/IR registers of the multi-cycle core, one instruction at a time. It decodes opcode/funct fields and drives per-state mux selects and write strobes. It handshakes with the single unified memory port via mem_req/mem_ready. It also provides retired-instruction counting and fault halting for bring-up.

---
 rtl/multicycle_controller.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle core: sequences fetch/decode/execute, drives
// datapath selects and strobes, and handshakes with the unified memory port.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_control,
  output logic [1:0]       result_src,
  output logic             halted,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEM_ADR = 4'd3,
    MEM_RD  = 4'd4,
    MEM_WB  = 4'd5,
    MEM_WR  = 4'd6,
    EXEC_R  = 4'd7,
    EXEC_I  = 4'd8,
    ALU_WB  = 4'd9,
    BEQ     = 4'd10,
    JAL     = 4'd11,
    HALT    = 4'd12
  } state_t;

  state_t            cur_state, next_state, decode_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic [1:0]        alu_decoded;
  logic              timed_out, retire, set_illegal, set_mem_err;

  assign state     = cur_state;
  assign halted    = (cur_state == HALT);
  assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Only R-type subtract uses funct7b5; I-type addi ignores it.
  always_comb begin
    alu_decoded = 2'b00;
    case (funct3)
      3'b000:  alu_decoded = (opcode == OP_RTYPE && funct7b5) ? 2'b01 : 2'b00;
      3'b110:  alu_decoded = 2'b11;
      3'b111:  alu_decoded = 2'b10;
      default: alu_decoded = 2'b00;
    endcase
  end

  always_comb begin
    decode_next = HALT;
    case (opcode)
      OP_LOAD, OP_STORE:  if (funct3 == 3'b010) decode_next = MEM_ADR;
      OP_RTYPE:           if (funct3 == 3'b000 || funct3 == 3'b110 || funct3 == 3'b111)
                            decode_next = EXEC_R;
      OP_ITYPE:           if (funct3 == 3'b000 || funct3 == 3'b110 || funct3 == 3'b111)
                            decode_next = EXEC_I;
      OP_BRANCH:          if (funct3 == 3'b000) decode_next = BEQ;
      OP_JAL:             decode_next = JAL;
      default:            decode_next = HALT;
    endcase
  end

  always_comb begin
    next_state  = cur_state;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 2'b00;
    result_src  = 2'b00;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_mem_err = 1'b0;
    case (cur_state)
      IDLE: next_state = FETCH;
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next_state = DECODE;
        else if (timed_out) begin
          next_state  = HALT;
          set_mem_err = 1'b1;
        end
      end
      DECODE: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b01;
        next_state  = decode_next;
        set_illegal = (decode_next == HALT);
      end
      MEM_ADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next_state = MEM_WB;
        else if (timed_out) begin
          next_state  = HALT;
          set_mem_err = 1'b1;
        end
      end
      MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        next_state = FETCH;
        retire     = 1'b1;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          next_state = FETCH;
          retire     = 1'b1;
        end else if (timed_out) begin
          next_state  = HALT;
          set_mem_err = 1'b1;
        end
      end
      EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = alu_decoded;
        next_state  = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_decoded;
        next_state  = ALU_WB;
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        next_state = FETCH;
        retire     = 1'b1;
      end
      BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 2'b01;
        pc_write    = zero;
        next_state  = FETCH;
        retire      = 1'b1;
      end
      // Target was latched into ALUOut during DECODE; the ALU now forms oldPC+4 for the link.
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        next_state = ALU_WB;
      end
      HALT:    next_state = HALT;
      default: next_state = HALT;
    endcase
  end

  always_comb begin
    wait_cnt_next = '0;
    if ((cur_state == FETCH || cur_state == MEM_RD || cur_state == MEM_WR) &&
        !mem_ready && next_state == cur_state)
      wait_cnt_next = wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
      wait_cnt  <= '0;
      instret   <= '0;
      illegal   <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      cur_state <= next_state;
      wait_cnt  <= wait_cnt_next;
      if (retire) instret <= instret + CNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
      if (set_mem_err) mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (TIMEOUT_CYCLES=4, 3-bit instret).
module tb_multicycle_controller;

  localparam int CNT_W = 3;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7b5, zero, mem_ready;
  logic             mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]       alu_src_a, alu_src_b, alu_control, result_src;
  logic             halted, illegal, mem_err;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state;
  logic [4:0]       strobes;

  int checkCount = 0;
  int passCount  = 0;

  multicycle_controller #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .result_src(result_src), .halted(halted), .illegal(illegal), .mem_err(mem_err),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  assign strobes = {mem_req, mem_write, ir_write, pc_write, reg_write};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic zr, input logic rdy);
    opcode    = op;
    funct3    = f3;
    funct7b5  = f7;
    zero      = zr;
    mem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] vecOp  [3] = '{OP_I, OP_I, OP_R};
  logic [2:0] vecF3  [3] = '{3'b110, 3'b000, 3'b111};
  logic       vecF7  [3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0] vecSt  [3] = '{4'd8, 4'd8, 4'd7};
  logic [1:0] vecAlu [3] = '{2'b11, 2'b00, 2'b10};
  logic [1:0] vecB   [3] = '{2'b01, 2'b01, 2'b00};

  initial begin
    rst = 1'b1;
    applyStimulus(OP_R, 3'b000, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_instret", instret, 0);
    checkOutput("rst_flags", {halted, illegal, mem_err}, 0);
    checkOutput("rst_strobes", strobes, 0);
    rst = 1'b0;

    // R-type sub with memory always ready
    tick();
    applyStimulus(OP_R, 3'b000, 1'b1, 1'b0, 1'b1);
    checkOutput("r_fetch_state", state, 1);
    checkOutput("r_fetch_strobes", strobes, 5'b10110);
    checkOutput("r_fetch_sel", {adr_src, alu_src_a, alu_src_b, alu_control, result_src},
                {1'b0, 2'b00, 2'b10, 2'b00, 2'b10});
    tick();
    checkOutput("r_decode", {state, alu_src_a, alu_src_b, alu_control, strobes},
                {4'd2, 2'b01, 2'b01, 2'b00, 5'b0});
    tick();
    checkOutput("r_exec", {state, alu_src_a, alu_src_b, alu_control, strobes},
                {4'd7, 2'b10, 2'b00, 2'b01, 5'b0});
    tick();
    checkOutput("r_aluwb", {state, result_src, strobes, instret}, {4'd9, 2'b00, 5'b00001, 3'd0});
    tick();
    checkOutput("r_retired", {state, strobes[0], instret}, {4'd1, 1'b0, 3'd1});

    // lw with three wait cycles in FETCH and MEM_RD (ready on the timeout cycle wins)
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_LD, 3'b010, 1'b0, 1'b0, 1'b0);
      checkOutput("lw_fetch_wait", {state, ir_write, pc_write}, {4'd1, 2'b00});
      tick();
    end
    applyStimulus(OP_LD, 3'b010, 1'b0, 1'b0, 1'b1);
    checkOutput("lw_fetch_ready", {state, ir_write, pc_write}, {4'd1, 2'b11});
    tick();
    checkOutput("lw_decode", state, 2);
    tick();
    applyStimulus(OP_LD, 3'b010, 1'b0, 1'b0, 1'b0);
    checkOutput("lw_memadr", {state, alu_src_a, alu_src_b, mem_req}, {4'd3, 2'b10, 2'b01, 1'b0});
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_LD, 3'b010, 1'b0, 1'b0, (i == 3));
      checkOutput("lw_memrd", {state, adr_src, mem_req, mem_write}, {4'd4, 1'b1, 1'b1, 1'b0});
      tick();
    end
    checkOutput("lw_memwb", {state, result_src, strobes, instret}, {4'd5, 2'b01, 5'b00001, 3'd1});
    tick();
    checkOutput("lw_retired", {state, instret}, {4'd1, 3'd2});

    // beq taken then not taken
    applyStimulus(OP_BR, 3'b000, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("beq_taken", {state, pc_write, alu_control, alu_src_a}, {4'd10, 1'b1, 2'b01, 2'b10});
    tick();
    checkOutput("beq1_instret", instret, 3);
    applyStimulus(OP_BR, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("beq_not_taken", {state, pc_write}, {4'd10, 1'b0});
    tick();
    checkOutput("beq2_instret", instret, 4);

    // jal retires once, via ALU_WB
    applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("jal_state", {state, pc_write, reg_write, alu_src_a, alu_src_b, instret},
                {4'd11, 1'b1, 1'b0, 2'b01, 2'b10, 3'd4});
    tick();
    checkOutput("jal_wb", {state, pc_write, reg_write, instret}, {4'd9, 1'b0, 1'b1, 3'd4});
    tick();
    checkOutput("jal_retired", instret, 5);

    // ALU decode table; three retirements wrap the 3-bit counter to 0
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecOp[i], vecF3[i], vecF7[i], 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("alu_decode", {state, alu_control, alu_src_b}, {vecSt[i], vecAlu[i], vecB[i]});
      tick();
      tick();
    end
    checkOutput("instret_wrap", instret, 0);

    // sw completes, then a second sw is interrupted by reset inside MEM_WR
    applyStimulus(OP_ST, 3'b010, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("sw_memadr", state, 3);
    tick();
    checkOutput("sw_memwr", {state, strobes, adr_src}, {4'd6, 5'b11000, 1'b1});
    tick();
    checkOutput("sw_retired", {state, instret}, {4'd1, 3'd1});
    tick();
    tick();
    tick();
    applyStimulus(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0);
    checkOutput("sw2_memwr", {state, mem_req}, {4'd6, 1'b1});
    rst = 1'b1;
    #1;
    checkOutput("sw2_rst_drop", {state, strobes, instret}, {4'd0, 5'b0, 3'd0});
    rst = 1'b0;

    // unsupported opcode halts with illegal set
    tick();
    applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("illegal_decode", {state, illegal}, {4'd2, 1'b0});
    tick();
    checkOutput("illegal_halt", {state, halted, illegal, mem_err}, {4'd12, 3'b110});
    for (int i = 0; i < 10; i++) begin
      applyStimulus(OP_R, 3'b000, 1'b0, 1'b1, i[0]);
      checkOutput("halt_hold", {state, strobes, instret}, {4'd12, 5'b0, 3'd0});
      tick();
    end
    rst = 1'b1;
    #1;
    checkOutput("halt_rst", {state, halted, illegal}, {4'd0, 2'b00});
    rst = 1'b0;

    // bad funct3 on an otherwise legal opcode
    tick();
    applyStimulus(OP_R, 3'b001, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("bad_funct3_r", {state, illegal}, {4'd12, 1'b1});
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    applyStimulus(OP_LD, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("bad_funct3_lw", {state, illegal}, {4'd12, 1'b1});
    rst = 1'b1;
    #1;
    rst = 1'b0;

    // fetch timeout after four stalled cycles
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("timeout_wait", state, 1);
      tick();
    end
    checkOutput("timeout_halt", {state, halted, illegal, mem_err}, {4'd12, 3'b101});
    rst = 1'b1;
    #1;
    checkOutput("timeout_rst", {state, mem_err}, {4'd0, 1'b0});
    rst = 1'b0;

    // ready on the fourth cycle avoids the timeout
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(OP_R, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("late_ready_irw", {state, ir_write}, {4'd1, 1'b1});
    tick();
    checkOutput("late_ready_decode", {state, mem_err, halted}, {4'd2, 2'b00});

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
